// File: rtl/bcd_display_scan.sv
// Six-digit multiplexed seven-segment scanner for a common-anode display.
// Snapshots all BCD digits once per frame, blanks leading zeros, marks bad codes.

module bcd_scan_lane (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h3F;
        if (blank) begin
            seg = 7'h7F;
        end else begin
            case (digit)
                4'd0:    seg = 7'h40;
                4'd1:    seg = 7'h79;
                4'd2:    seg = 7'h24;
                4'd3:    seg = 7'h30;
                4'd4:    seg = 7'h19;
                4'd5:    seg = 7'h12;
                4'd6:    seg = 7'h02;
                4'd7:    seg = 7'h78;
                4'd8:    seg = 7'h00;
                4'd9:    seg = 7'h10;
                default: seg = 7'h3F;  // 10..15 shown as a dash
            endcase
        end
    end
endmodule

module bcd_display_scan #(
    parameter int SCAN_BITS  = 16,
    parameter int SCAN_COUNT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] digit0_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit3_i,
    input  logic [3:0] digit4_i,
    input  logic [3:0] digit5_i,
    output logic [6:0] seg_o,
    output logic [5:0] an_o,
    output logic [2:0] sel_o,
    output logic       frame_o
);
    localparam int                   NUM_DIGITS = 6;
    localparam logic [SCAN_BITS-1:0] PRESC_LAST = SCAN_BITS'(SCAN_COUNT - 1);
    localparam logic [2:0]           SEL_LAST   = 3'd5;

    logic [SCAN_BITS-1:0]            presc;
    logic [2:0]                      sel;
    logic [NUM_DIGITS-1:0][3:0]      snap;
    logic [NUM_DIGITS-1:0][3:0]      din;
    logic [NUM_DIGITS-1:0]           blank;
    logic [NUM_DIGITS-1:0][6:0]      lane_seg;
    logic                            tick;
    logic                            wrap;
    logic                            zrun;

    assign din  = {digit5_i, digit4_i, digit3_i, digit2_i, digit1_i, digit0_i};
    assign tick = en && (presc == PRESC_LAST);
    assign wrap = tick && (sel == SEL_LAST);

    // A digit blanks only if it and every more-significant digit are zero.
    always_comb begin
        blank = '0;
        zrun  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zrun     = zrun & (snap[k] == 4'd0);
            blank[k] = blank_lz & zrun;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_lane
            bcd_scan_lane u_lane (
                .digit (snap[g]),
                .blank (blank[g]),
                .seg   (lane_seg[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            sel   <= '0;
            snap  <= '0;
        end else begin
            if (tick)
                presc <= '0;
            else if (en)
                presc <= presc + SCAN_BITS'(1);
            if (tick)
                sel <= wrap ? 3'd0 : sel + 3'd1;
            // Frame-coherent capture: inputs only sampled at the frame boundary.
            if (wrap)
                snap <= din;
        end
    end

    // Outputs register the current scan state, one clock behind sel/snap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_o   <= 7'h7F;
            an_o    <= 6'h3F;
            sel_o   <= 3'd0;
            frame_o <= 1'b0;
        end else begin
            frame_o <= wrap;
            if (en) begin
                an_o  <= ~(6'd1 << sel);
                sel_o <= sel;
                seg_o <= lane_seg[sel];
            end else begin
                an_o  <= 6'h3F;
                seg_o <= 7'h7F;
            end
        end
    end
endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: expected per-digit outputs are queued
// when digits are driven and popped as each digit dwell appears on the pins.

module tb_bcd_display_scan;
    localparam int SC = 4;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic [2:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, blank_lz;
    logic [3:0] dg0, dg1, dg2, dg3, dg4, dg5;
    logic [6:0] seg_o;
    logic [5:0] an_o;
    logic [2:0] sel_o;
    logic       frame_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    bcd_display_scan #(.SCAN_BITS(16), .SCAN_COUNT(SC)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .blank_lz (blank_lz),
        .digit0_i (dg0),
        .digit1_i (dg1),
        .digit2_i (dg2),
        .digit3_i (dg3),
        .digit4_i (dg4),
        .digit5_i (dg5),
        .seg_o    (seg_o),
        .an_o     (an_o),
        .sel_o    (sel_o),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_digits(input logic [3:0] a0, a1, a2, a3, a4, a5);
        dg0 = a0; dg1 = a1; dg2 = a2; dg3 = a3; dg4 = a4; dg5 = a5;
    endtask

    // s[k] is the expected segment pattern for digit k.
    task automatic push_frame(input logic [5:0][6:0] s);
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            e.an  = ~(6'd1 << k);
            e.seg = s[k];
            e.sel = 3'(k);
            sb.push_back(e);
        end
    endtask

    // Returns at the first negedge showing frame_o after the call.
    task automatic wait_frame();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (frame_o) return;
        end
        chk("frame_timeout", 32'd0, 32'd1);
    endtask

    // Checks one full frame from the negedge where frame_o was seen.
    task automatic check_frame(input bit change_mid, input bit hold_mid);
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
                return;
            end
            e = sb.pop_front();
            for (int c = 0; c < SC; c++) begin
                @(negedge clk);
                chk("an",    32'(an_o),    32'(e.an));
                chk("seg",   32'(seg_o),   32'(e.seg));
                chk("sel",   32'(sel_o),   32'(e.sel));
                chk("frame", 32'(frame_o), 32'(k == 5 && c == SC - 1));
                if (change_mid && k == 1 && c == 0) begin
                    dg2 = 4'd9;
                    push_frame({7'h40, 7'h40, 7'h40, 7'h10, 7'h40, 7'h40});
                end
                if (hold_mid && k == 3 && c == 1) begin
                    en = 1'b0;
                    for (int i = 0; i < 10; i++) begin
                        @(negedge clk);
                        chk("hold_an",    32'(an_o),    32'h3F);
                        chk("hold_seg",   32'(seg_o),   32'h7F);
                        chk("hold_sel",   32'(sel_o),   32'd3);
                        chk("hold_frame", 32'(frame_o), 32'd0);
                    end
                    en = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0;
        blank_lz = 1'b0;
        set_digits(4'($urandom), 4'($urandom), 4'($urandom),
                   4'($urandom), 4'($urandom), 4'($urandom));
        repeat (3) @(negedge clk);
        chk("rst_seg",   32'(seg_o),   32'h7F);
        chk("rst_an",    32'(an_o),    32'h3F);
        chk("rst_frame", 32'(frame_o), 32'd0);
        chk("rst_sel",   32'(sel_o),   32'd0);

        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        chk("first_an",  32'(an_o),  32'h3E);
        chk("first_seg", 32'(seg_o), 32'h40);

        // Plain scan of 5,4,3,2,1,0 with no blanking.
        set_digits(4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0);
        push_frame({7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
        wait_frame();
        check_frame(1'b0, 1'b0);

        blank_lz = 1'b1;
        set_digits(4'd7, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0);
        push_frame({7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h78});
        wait_frame();
        check_frame(1'b0, 1'b0);

        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        push_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        wait_frame();
        check_frame(1'b0, 1'b0);

        // Invalid code is a dash and still stops blanking below it.
        set_digits(4'd0, 4'd0, 4'd0, 4'hC, 4'd0, 4'd0);
        push_frame({7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h40, 7'h40});
        wait_frame();
        check_frame(1'b0, 1'b0);

        // Coherence: digit2 changes during sel 1, shows up only next frame.
        blank_lz = 1'b0;
        set_digits(4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);
        push_frame({7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40});
        wait_frame();
        check_frame(1'b1, 1'b0);
        check_frame(1'b0, 1'b0);

        // Enable drop mid-dwell on digit 3; digits unchanged so frame chains.
        push_frame({7'h40, 7'h40, 7'h40, 7'h10, 7'h40, 7'h40});
        check_frame(1'b0, 1'b1);

        // Asynchronous reset mid-frame.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_seg",   32'(seg_o),   32'h7F);
        chk("mid_rst_an",    32'(an_o),    32'h3F);
        chk("mid_rst_sel",   32'(sel_o),   32'd0);
        chk("mid_rst_frame", 32'(frame_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rerel_an",  32'(an_o),  32'h3E);
        chk("rerel_seg", 32'(seg_o), 32'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
